// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation controller. It steps an LFSR challenge, fires launch edges
// into the delay chain, majority-votes the synchronized arbiter result, and packs the voted bits into a word.
module puf_eval_ctrl #(
    parameter int                CHAL_W     = 32,
    parameter logic [CHAL_W-1:0] TAPS       = CHAL_W'(32'h80200003),
    parameter int                SETTLE_CYC = 8,
    parameter int                VOTES      = 5,
    parameter int                RESP_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [CHAL_W-1:0] seed_i,
    output logic              busy_o,
    output logic [CHAL_W-1:0] challenge_o,
    output logic              launch_o,
    input  logic              arb_out_i,
    output logic [RESP_W-1:0] resp_o,
    output logic              resp_valid_o,
    input  logic              resp_ready_i
);

    localparam int CW = $clog2(SETTLE_CYC + 2);
    localparam int VW = $clog2(VOTES + 1);
    localparam int BW = $clog2(RESP_W + 1);

    localparam logic [CW-1:0] ARM_LAST  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] FIRE_LAST = CW'(SETTLE_CYC + 1);
    localparam logic [VW-1:0] VOTES_N   = VW'(VOTES);
    localparam logic [VW-1:0] VOTES_HLF = VW'(VOTES / 2);
    localparam logic [BW-1:0] BITS_N    = BW'(RESP_W);

    typedef enum logic [2:0] {IDLE, LOAD, ARM, FIRE, ADV, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [VW-1:0]     trial_q, trial_d;
    logic [VW-1:0]     ones_q, ones_d;
    logic [BW-1:0]     bits_q, bits_d;
    logic [CHAL_W-1:0] chal_q, chal_d;
    logic [RESP_W-1:0] resp_q, resp_d;
    logic              sync1_q, sync2_q;
    logic              vote_bit;
    logic [RESP_W:0]   resp_shift;

    // Two-flop synchronizer for the asynchronous arbiter decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= arb_out_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            trial_q <= '0;
            ones_q  <= '0;
            bits_q  <= '0;
            chal_q  <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            trial_q <= trial_d;
            ones_q  <= ones_d;
            bits_q  <= bits_d;
            chal_q  <= chal_d;
            resp_q  <= resp_d;
        end
    end

    assign vote_bit   = (ones_q > VOTES_HLF);
    assign resp_shift = {vote_bit, resp_q};

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        trial_d = trial_q;
        ones_d  = ones_q;
        bits_d  = bits_q;
        chal_d  = chal_q;
        resp_d  = resp_q;
        case (state_q)
            IDLE: if (start_i) state_d = LOAD;
            LOAD: begin
                // An all-zero LFSR state would never advance.
                chal_d  = (seed_i == '0) ? CHAL_W'(1) : seed_i;
                cyc_d   = '0;
                trial_d = '0;
                ones_d  = '0;
                bits_d  = '0;
                state_d = ARM;
            end
            ARM: begin
                if (cyc_q == ARM_LAST) begin
                    cyc_d   = '0;
                    state_d = FIRE;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            FIRE: begin
                if (cyc_q == FIRE_LAST) begin
                    cyc_d   = '0;
                    ones_d  = ones_q + VW'(sync2_q);
                    trial_d = trial_q + VW'(1);
                    state_d = (trial_d < VOTES_N) ? ARM : ADV;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            ADV: begin
                // First voted bit ends up in resp[0] after RESP_W shifts.
                resp_d  = resp_shift[RESP_W:1];
                chal_d  = {chal_q[CHAL_W-2:0], ^(chal_q & TAPS)};
                ones_d  = '0;
                trial_d = '0;
                cyc_d   = '0;
                bits_d  = bits_q + BW'(1);
                state_d = (bits_d < BITS_N) ? ARM : DONE;
            end
            DONE: if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o       = (state_q != IDLE);
    assign launch_o     = (state_q == FIRE);
    assign resp_valid_o = (state_q == DONE);
    assign challenge_o  = chal_q;
    assign resp_o       = resp_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Randomized scoreboard bench for puf_eval_ctrl: arbiter decisions are scripted per trial
// and the expected word, final challenge and latency come from a majority/LFSR reference model.
module tb_puf_eval_ctrl;
    localparam int          CHAL_W = 32;
    localparam int          SETTLE = 8;
    localparam int          VOTES  = 5;
    localparam int          RESP_W = 16;
    localparam int          LAT    = 1457;
    localparam logic [31:0] TAPS   = 32'h80200003;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [CHAL_W-1:0] seed_i = '0;
    logic              busy_o;
    logic [CHAL_W-1:0] challenge_o;
    logic              launch_o;
    logic              arb_out_i = 1'b0;
    logic [RESP_W-1:0] resp_o;
    logic              resp_valid_o;
    logic              resp_ready_i = 1'b0;

    puf_eval_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .seed_i(seed_i), .busy_o(busy_o),
        .challenge_o(challenge_o), .launch_o(launch_o), .arb_out_i(arb_out_i),
        .resp_o(resp_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RESP_W-1:0] resp;
        logic [CHAL_W-1:0] chal;
        int                due;
    } exp_t;

    exp_t        exp_q[$];
    bit          vote_q[$];
    bit          pat[RESP_W*VOTES];
    logic [31:0] exp_chal[RESP_W];
    int          rise_cnt = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] c);
        logic fb;
        fb = 1'($countones(c & TAPS) % 2);
        return {c[30:0], fb};
    endfunction

    // Arbiter driver plus launch/challenge discipline monitor.
    logic        lprev = 1'b0;
    logic        chal_bad = 1'b0;
    logic [31:0] chal_hi = '0;
    int          low_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            lprev    = 1'b0;
            chal_bad = 1'b0;
            low_cnt  = 0;
        end else begin
            if (launch_o && !lprev) begin
                chk("launch_low_cycles", 64'(low_cnt >= SETTLE), 64'd1);
                if ((rise_cnt % VOTES) == 0 && (rise_cnt / VOTES) < RESP_W)
                    chk("challenge_at_bit", challenge_o, exp_chal[rise_cnt / VOTES]);
                chal_hi   = challenge_o;
                arb_out_i = (vote_q.size() > 0) ? vote_q.pop_front() : 1'b0;
                rise_cnt++;
                low_cnt   = 0;
            end else if (launch_o) begin
                if (challenge_o !== chal_hi) chal_bad = 1'b1;
            end else begin
                if (lprev) begin
                    chk("challenge_stable_high", 64'(chal_bad), 64'd0);
                    chal_bad = 1'b0;
                end
                low_cnt++;
                arb_out_i = 1'($urandom_range(0, 1));
            end
            lprev = launch_o;
        end
    end

    // Scoreboard monitor: latency on valid rise, hold stability, word on handshake.
    logic              vprev = 1'b0;
    logic [RESP_W-1:0] rprev = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            vprev = 1'b0;
        end else begin
            if (resp_valid_o && !vprev) begin
                if (exp_q.size() > 0) chk("valid_latency", 64'(cyc), 64'(exp_q[0].due));
                else                  chk("unexpected_valid", 64'd1, 64'd0);
            end
            if (resp_valid_o && vprev) chk("resp_hold_stable", resp_o, rprev);
            if (resp_valid_o && resp_ready_i && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_word", resp_o, e.resp);
                chk("final_challenge", challenge_o, e.chal);
            end
            vprev = resp_valid_o;
            rprev = resp_o;
        end
    end

    task automatic rand_pat();
        for (int i = 0; i < RESP_W*VOTES; i++) pat[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic start_word(input logic [31:0] seed);
        logic [31:0]       c;
        logic [RESP_W-1:0] r;
        int                ones;
        exp_t              e;
        c = (seed == 0) ? 32'd1 : seed;
        r = '0;
        for (int b = 0; b < RESP_W; b++) begin
            exp_chal[b] = c;
            ones = 0;
            for (int t = 0; t < VOTES; t++) begin
                ones += int'(pat[b*VOTES + t]);
                vote_q.push_back(pat[b*VOTES + t]);
            end
            r[b] = (ones > VOTES / 2);
            c = lfsr_next(c);
        end
        rise_cnt = 0;
        @(posedge clk); #1;
        start_i = 1'b1;
        seed_i  = seed;
        @(posedge clk); #1;
        start_i = 1'b0;
        e.resp = r;
        e.chal = c;
        e.due  = cyc + LAT;
        exp_q.push_back(e);
        @(posedge clk); #1;
        seed_i = $urandom;
    endtask

    task automatic finish_word(input int hold);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < LAT + 200; n++) begin
            @(negedge clk);
            if (resp_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("resp_valid_timeout", 64'd0, 64'd1);
            return;
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            start_i = (k == hold / 2);
            seed_i  = $urandom;
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_valid", 64'(resp_valid_o), 64'd0);
        repeat (3) @(negedge clk);
        chk("start_ignored_busy", 64'(busy_o), 64'd0);
    endtask

    initial begin
        #12;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_launch", 64'(launch_o), 64'd0);
        chk("rst_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_resp", resp_o, 64'd0);
        chk("rst_challenge", challenge_o, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // All-ones arbiter, seed 1.
        for (int i = 0; i < RESP_W*VOTES; i++) pat[i] = 1'b1;
        start_word(32'h1);
        finish_word(0);

        // Bit 0 wins 3 of 5, then loses with 2 of 5.
        rand_pat();
        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 1;
        start_word($urandom);
        finish_word(2);
        rand_pat();
        pat[0] = 1; pat[1] = 1; pat[2] = 0; pat[3] = 0; pat[4] = 0;
        start_word($urandom);
        finish_word(1);

        // Zero seed and a fixed seed through the LFSR.
        rand_pat();
        start_word(32'h0);
        finish_word(0);
        rand_pat();
        start_word(32'hDEADBEEF);
        finish_word(0);

        // Long backpressure hold with a start pulse inside DONE.
        rand_pat();
        start_word($urandom);
        finish_word(20);

        // Reset during FIRE of bit 7.
        rand_pat();
        start_word($urandom);
        begin
            bit hit;
            hit = 1'b0;
            for (int n = 0; n < LAT; n++) begin
                @(posedge clk); #1;
                if (rise_cnt >= 7*VOTES + 1) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("reach_bit7_fire", 64'(hit), 64'd1);
        end
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_launch", 64'(launch_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_valid", 64'(resp_valid_o), 64'd0);
        chk("midrst_resp", resp_o, 64'd0);
        exp_q.delete();
        vote_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int w = 0; w < 2; w++) begin
            rand_pat();
            start_word($urandom);
            finish_word(w * 3);
        end

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
